// File: rtl/multi_rule_flow_stat_pkg.sv
`default_nettype none
// ============================================================================
// Module : flow_stat_pkg
// Brief  : Shared constants, tuple layout and parser encoding for the
//          multi-rule 5-tuple flow statistics block.
// Rev    : 1.0
// ============================================================================
package flow_stat_pkg;

    localparam int TUPLE_W    = 104;
    localparam int META_BYTES = 32;
    localparam int PKT_DATA_W = 134;
    localparam int LEN_W      = 12;

    localparam logic [15:0] ETH_VLAN  = 16'h8100;
    localparam logic [15:0] ETH_IPV4  = 16'h0800;
    localparam logic [7:0]  PROTO_TCP = 8'h06;
    localparam logic [7:0]  PROTO_UDP = 8'h11;

    // Tuple: src IP | dst IP | protocol | src port | dst port (MSB first)
    localparam int SRC_IP_LSB = 72;
    localparam int DST_IP_LSB = 40;
    localparam int PROTO_LSB  = 32;
    localparam int SPORT_LSB  = 16;
    localparam int DPORT_LSB  = 0;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MD1  = 3'd1;
    localparam logic [2:0] ST_ETH  = 3'd2;
    localparam logic [2:0] ST_IP   = 3'd3;
    localparam logic [2:0] ST_L4   = 3'd4;

    typedef logic [TUPLE_W-1:0] tuple_t;

    function automatic logic is_l4_proto(input logic [7:0] proto);
        return (proto == PROTO_TCP) || (proto == PROTO_UDP);
    endfunction

    function automatic logic [LEN_W-1:0] payload_bytes(input logic [LEN_W-1:0] len);
        return (len >= LEN_W'(META_BYTES)) ? len - LEN_W'(META_BYTES) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_rule_flow_stat_if.sv
`default_nettype none
// ============================================================================
// Module : multi_rule_flow_stat_if
// Brief  : Packet stream input and indexed counter read port.
// Rev    : 1.0
// ============================================================================
interface multi_rule_flow_stat_if
    import flow_stat_pkg::*;
#(
    parameter int NUM_RULES = 8,
    parameter int BYTE_W    = 40,
    parameter int PKT_W     = 32,
    parameter int IDX_W     = $clog2(NUM_RULES + 1)
);
    logic [PKT_DATA_W-1:0] pktin_data;
    logic                  pktin_data_wr;
    logic                  rd_req;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_clr;
    logic                  rd_valid;
    logic [BYTE_W-1:0]     rd_byte;
    logic [PKT_W-1:0]      rd_pkt;

    modport master (
        output pktin_data, pktin_data_wr, rd_req, rd_idx, rd_clr,
        input  rd_valid, rd_byte, rd_pkt
    );

    modport slave (
        input  pktin_data, pktin_data_wr, rd_req, rd_idx, rd_clr,
        output rd_valid, rd_byte, rd_pkt
    );
endinterface
`default_nettype wire

// File: rtl/multi_rule_flow_stat_parser.sv
`default_nettype none
// ============================================================================
// Module : flow_tuple_parser
// Brief  : Extracts the IPv4 TCP/UDP 5-tuple (untagged or single VLAN) from
//          the metadata-prefixed stream; flags non-matching packets.
// Rev    : 1.0
// ============================================================================
module flow_tuple_parser
    import flow_stat_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PKT_DATA_W-1:0] pktin_data,
    input  logic                  pktin_data_wr,
    output tuple_t                tuple,
    output logic                  tuple_vld,
    output logic                  nomatch_vld,
    output logic [LEN_W-1:0]      byte_inc
);
    logic [2:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic             r_vlan;
    tuple_t           r_tuple;
    logic             r_tuple_vld;
    logic             r_nomatch_vld;
    logic             w_is_hdr;
    logic [15:0]      w_eth_type;
    logic             w_unused_meta;

    assign w_is_hdr      = (pktin_data[133:132] == 2'b01);
    assign w_eth_type    = pktin_data[31:16];
    assign w_unused_meta = ^pktin_data[131:128];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_vlan        <= 1'b0;
            r_tuple       <= '0;
            r_tuple_vld   <= 1'b0;
            r_nomatch_vld <= 1'b0;
        end else begin
            r_tuple_vld   <= 1'b0;
            r_nomatch_vld <= 1'b0;
            if (pktin_data_wr) begin
                // A header word always (re)starts a parse, dropping any packet in flight
                if (w_is_hdr) begin
                    r_len   <= pktin_data[107:96];
                    r_state <= ST_MD1;
                end else begin
                    case (r_state)
                        ST_MD1: r_state <= ST_ETH;
                        ST_ETH: begin
                            if (w_eth_type == ETH_VLAN) begin
                                r_vlan  <= 1'b1;
                                r_state <= ST_IP;
                            end else if (w_eth_type == ETH_IPV4) begin
                                r_vlan  <= 1'b0;
                                r_state <= ST_IP;
                            end else begin
                                r_nomatch_vld <= 1'b1;
                                r_state       <= ST_IDLE;
                            end
                        end
                        ST_IP: begin
                            if (r_vlan) begin
                                if (pktin_data[127:112] == ETH_IPV4 && is_l4_proto(pktin_data[39:32])) begin
                                    r_tuple[PROTO_LSB +: 8]       <= pktin_data[39:32];
                                    r_tuple[SRC_IP_LSB+16 +: 16]  <= pktin_data[15:0];
                                    r_state                       <= ST_L4;
                                end else begin
                                    r_nomatch_vld <= 1'b1;
                                    r_state       <= ST_IDLE;
                                end
                            end else begin
                                if (is_l4_proto(pktin_data[71:64])) begin
                                    r_tuple[PROTO_LSB +: 8]       <= pktin_data[71:64];
                                    r_tuple[SRC_IP_LSB +: 32]     <= pktin_data[47:16];
                                    r_tuple[DST_IP_LSB+16 +: 16]  <= pktin_data[15:0];
                                    r_state                       <= ST_L4;
                                end else begin
                                    r_nomatch_vld <= 1'b1;
                                    r_state       <= ST_IDLE;
                                end
                            end
                        end
                        ST_L4: begin
                            if (r_vlan) begin
                                r_tuple[SRC_IP_LSB +: 16] <= pktin_data[127:112];
                                r_tuple[DST_IP_LSB +: 32] <= pktin_data[111:80];
                                r_tuple[SPORT_LSB +: 16]  <= pktin_data[79:64];
                                r_tuple[DPORT_LSB +: 16]  <= pktin_data[63:48];
                            end else begin
                                r_tuple[DST_IP_LSB +: 16] <= pktin_data[127:112];
                                r_tuple[SPORT_LSB +: 16]  <= pktin_data[111:96];
                                r_tuple[DPORT_LSB +: 16]  <= pktin_data[95:80];
                            end
                            r_tuple_vld <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign tuple       = r_tuple;
    assign tuple_vld   = r_tuple_vld;
    assign nomatch_vld = r_nomatch_vld;
    assign byte_inc    = payload_bytes(r_len);

endmodule
`default_nettype wire

// File: rtl/multi_rule_flow_stat.sv
`default_nettype none
// ============================================================================
// Module : multi_rule_flow_stat
// Brief  : Masked multi-rule 5-tuple matcher with per-rule byte/packet
//          counters, a miss counter and an indexed read/read-clear port.
// Rev    : 1.0
// ============================================================================
module multi_rule_flow_stat
    import flow_stat_pkg::*;
#(
    parameter int NUM_RULES  = 8,
    parameter int BYTE_W     = 40,
    parameter int PKT_W      = 32,
    parameter int MATCH_MODE = 0,
    parameter int SATURATE   = 1,
    parameter int IDX_W      = $clog2(NUM_RULES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RULES*TUPLE_W-1:0] rule_5tuple,
    input  logic [NUM_RULES*TUPLE_W-1:0] rule_mask,
    input  logic [NUM_RULES-1:0]         rule_en,
    input  logic                         cnt_clr,
    multi_rule_flow_stat_if.slave        bus
);
    localparam int               SUM_W    = ((BYTE_W > LEN_W) ? BYTE_W : LEN_W) + 1;
    localparam logic [BYTE_W-1:0] BYTE_MAX = '1;
    localparam logic [PKT_W-1:0]  PKT_MAX  = '1;

    tuple_t               w_tuple;
    logic                 w_tuple_vld;
    logic                 w_nomatch_vld;
    logic [LEN_W-1:0]     w_byte_inc;
    logic [NUM_RULES-1:0] w_hit;
    logic [NUM_RULES-1:0] w_sel;
    logic                 r_m_vld;
    logic [NUM_RULES-1:0] r_m_sel;
    logic [LEN_W-1:0]     r_m_inc;
    logic [NUM_RULES:0]   w_upd;
    logic [NUM_RULES:0]   w_rd_clr_hit;
    logic [BYTE_W-1:0]    w_b_base;
    logic [PKT_W-1:0]     w_p_base;
    logic [BYTE_W-1:0]    w_rd_b;
    logic [PKT_W-1:0]     w_rd_p;
    // Index NUM_RULES is the miss counter
    logic [BYTE_W-1:0]    r_byte     [NUM_RULES+1];
    logic [PKT_W-1:0]     r_pkt      [NUM_RULES+1];
    logic [BYTE_W-1:0]    w_byte_nxt [NUM_RULES+1];
    logic [PKT_W-1:0]     w_pkt_nxt  [NUM_RULES+1];
    logic                 r_rd_valid;
    logic [BYTE_W-1:0]    r_rd_byte;
    logic [PKT_W-1:0]     r_rd_pkt;

    function automatic logic [BYTE_W-1:0] add_bytes(input logic [BYTE_W-1:0] base,
                                                    input logic [LEN_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(inc);
        if (SATURATE != 0 && sum > SUM_W'(BYTE_MAX)) return BYTE_MAX;
        return sum[BYTE_W-1:0];
    endfunction

    function automatic logic [PKT_W-1:0] add_pkt(input logic [PKT_W-1:0] base);
        if (SATURATE != 0 && base == PKT_MAX) return PKT_MAX;
        return base + PKT_W'(1);
    endfunction

    flow_tuple_parser u_parser (
        .clk         (clk),
        .rst         (rst),
        .pktin_data  (bus.pktin_data),
        .pktin_data_wr(bus.pktin_data_wr),
        .tuple       (w_tuple),
        .tuple_vld   (w_tuple_vld),
        .nomatch_vld (w_nomatch_vld),
        .byte_inc    (w_byte_inc)
    );

    for (genvar i = 0; i < NUM_RULES; i++) begin : g_hit
        assign w_hit[i] = rule_en[i] &
            ~|((w_tuple ^ rule_5tuple[i*TUPLE_W +: TUPLE_W]) & rule_mask[i*TUPLE_W +: TUPLE_W]);
    end

    if (MATCH_MODE == 0) begin : g_first_match
        // Two's complement isolates the lowest set bit
        assign w_sel = w_hit & (-w_hit);
    end else begin : g_all_match
        assign w_sel = w_hit;
    end

    // An aborted packet enters the pipeline with an empty selection and lands on the miss counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_vld <= 1'b0;
            r_m_sel <= '0;
            r_m_inc <= '0;
        end else begin
            r_m_vld <= w_tuple_vld | w_nomatch_vld;
            r_m_sel <= w_tuple_vld ? w_sel : '0;
            r_m_inc <= w_byte_inc;
        end
    end

    always_comb begin
        w_upd        = {~|r_m_sel, r_m_sel} & {(NUM_RULES+1){r_m_vld}};
        w_rd_clr_hit = '0;
        w_rd_b       = '0;
        w_rd_p       = '0;
        w_b_base     = '0;
        w_p_base     = '0;
        for (int k = 0; k <= NUM_RULES; k++) begin
            w_rd_clr_hit[k] = bus.rd_req & bus.rd_clr & (bus.rd_idx == IDX_W'(k));
            if (bus.rd_idx == IDX_W'(k)) begin
                w_rd_b = r_byte[k];
                w_rd_p = r_pkt[k];
            end
            // Read-clear and update in the same cycle leave exactly the new increment
            w_b_base      = w_rd_clr_hit[k] ? '0 : r_byte[k];
            w_p_base      = w_rd_clr_hit[k] ? '0 : r_pkt[k];
            w_byte_nxt[k] = w_upd[k] ? add_bytes(w_b_base, r_m_inc) : w_b_base;
            w_pkt_nxt[k]  = w_upd[k] ? add_pkt(w_p_base) : w_p_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= NUM_RULES; k++) begin
                r_byte[k] <= '0;
                r_pkt[k]  <= '0;
            end
        end else if (cnt_clr) begin
            for (int k = 0; k <= NUM_RULES; k++) begin
                r_byte[k] <= '0;
                r_pkt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k <= NUM_RULES; k++) begin
                r_byte[k] <= w_byte_nxt[k];
                r_pkt[k]  <= w_pkt_nxt[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_byte  <= '0;
            r_rd_pkt   <= '0;
        end else begin
            r_rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                r_rd_byte <= cnt_clr ? '0 : w_rd_b;
                r_rd_pkt  <= cnt_clr ? '0 : w_rd_p;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_byte  = r_rd_byte;
    assign bus.rd_pkt   = r_rd_pkt;

endmodule
`default_nettype wire

// File: tb/tb_multi_rule_flow_stat.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_rule_flow_stat
// Brief  : Directed bench driving four configurations with a shared stream.
// Rev    : 1.0
// ============================================================================
module tb_multi_rule_flow_stat;
    logic         clk;
    logic         rst;
    logic [133:0] pkt_data;
    logic         pkt_wr;
    logic         rd_req;
    logic [3:0]   rd_idx;
    logic         rd_clr;
    logic         cnt_clr;
    logic [831:0] rule_5tuple;
    logic [831:0] rule_mask;
    logic [7:0]   rule_en;

    int errors = 0;
    int checks = 0;

    logic [133:0] wq [$];
    logic [133:0] l4_word;
    logic [63:0]  ob [4];
    logic [63:0]  op [4];
    logic         ov [4];

    localparam logic [103:0] T_A = {32'h0A000001, 32'h0A000002, 8'h11, 16'h1234, 16'h5678};
    localparam logic [103:0] T_B = {32'hC0A80101, 32'hC0A80102, 8'h06, 16'h0050, 16'h1F90};
    localparam logic [103:0] T_C = {32'h01020304, 32'h05060708, 8'h06, 16'h03E8, 16'h07D0};
    localparam logic [103:0] T_ICMP = {32'h0A000001, 32'h0A000002, 8'h01, 16'h1234, 16'h5678};

    multi_rule_flow_stat_if #(.NUM_RULES(8), .BYTE_W(40), .PKT_W(32)) if0 ();
    multi_rule_flow_stat_if #(.NUM_RULES(8), .BYTE_W(40), .PKT_W(32)) if1 ();
    multi_rule_flow_stat_if #(.NUM_RULES(8), .BYTE_W(8),  .PKT_W(32)) if2 ();
    multi_rule_flow_stat_if #(.NUM_RULES(8), .BYTE_W(8),  .PKT_W(32)) if3 ();

    assign {if0.pktin_data, if0.pktin_data_wr, if0.rd_req, if0.rd_idx, if0.rd_clr} = {pkt_data, pkt_wr, rd_req, rd_idx, rd_clr};
    assign {if1.pktin_data, if1.pktin_data_wr, if1.rd_req, if1.rd_idx, if1.rd_clr} = {pkt_data, pkt_wr, rd_req, rd_idx, rd_clr};
    assign {if2.pktin_data, if2.pktin_data_wr, if2.rd_req, if2.rd_idx, if2.rd_clr} = {pkt_data, pkt_wr, rd_req, rd_idx, rd_clr};
    assign {if3.pktin_data, if3.pktin_data_wr, if3.rd_req, if3.rd_idx, if3.rd_clr} = {pkt_data, pkt_wr, rd_req, rd_idx, rd_clr};

    multi_rule_flow_stat #(.NUM_RULES(8), .BYTE_W(40), .PKT_W(32), .MATCH_MODE(0), .SATURATE(1)) dut0 (
        .clk(clk), .rst(rst), .rule_5tuple(rule_5tuple), .rule_mask(rule_mask),
        .rule_en(rule_en), .cnt_clr(cnt_clr), .bus(if0));
    multi_rule_flow_stat #(.NUM_RULES(8), .BYTE_W(40), .PKT_W(32), .MATCH_MODE(1), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .rule_5tuple(rule_5tuple), .rule_mask(rule_mask),
        .rule_en(rule_en), .cnt_clr(cnt_clr), .bus(if1));
    multi_rule_flow_stat #(.NUM_RULES(8), .BYTE_W(8), .PKT_W(32), .MATCH_MODE(0), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .rule_5tuple(rule_5tuple), .rule_mask(rule_mask),
        .rule_en(rule_en), .cnt_clr(cnt_clr), .bus(if2));
    multi_rule_flow_stat #(.NUM_RULES(8), .BYTE_W(8), .PKT_W(32), .MATCH_MODE(0), .SATURATE(0)) dut3 (
        .clk(clk), .rst(rst), .rule_5tuple(rule_5tuple), .rule_mask(rule_mask),
        .rule_en(rule_en), .cnt_clr(cnt_clr), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [133:0] hdr(input logic [11:0] len);
        logic [133:0] w;
        w = '0;
        w[133:132] = 2'b01;
        w[107:96]  = len;
        return w;
    endfunction

    task automatic build_pkt(input bit vlan, input logic [11:0] len, input logic [103:0] t);
        logic [133:0] w;
        wq.delete();
        wq.push_back(hdr(len));
        wq.push_back(134'h0);
        w = '0;
        w[127:80] = 48'h0011_2233_4455;
        w[31:16]  = vlan ? 16'h8100 : 16'h0800;
        wq.push_back(w);
        w = '0;
        if (vlan) begin
            w[127:112] = 16'h0800; w[111:96] = 16'h4500;
            w[39:32]   = t[39:32]; w[15:0]   = t[103:88];
        end else begin
            w[127:112] = 16'h4500; w[71:64] = t[39:32];
            w[47:16]   = t[103:72]; w[15:0] = t[71:56];
        end
        wq.push_back(w);
        w = '0;
        if (vlan) begin
            w[127:112] = t[87:72]; w[111:80] = t[71:40];
            w[79:64]   = t[31:16]; w[63:48]  = t[15:0];
        end else begin
            w[127:112] = t[55:40]; w[111:96] = t[31:16]; w[95:80] = t[15:0];
        end
        wq.push_back(w);
    endtask

    // Entered just after a rising edge; idle gap cycles carry a decoy header with wr low
    task automatic send(input int gap);
        for (int i = 0; i < wq.size(); i++) begin
            pkt_data = wq[i];
            pkt_wr   = 1'b1;
            @(posedge clk); #1;
            pkt_wr   = 1'b0;
            pkt_data = '0;
            if (i != wq.size() - 1) begin
                repeat (gap) begin
                    pkt_data = hdr(12'd999);
                    @(posedge clk); #1;
                end
            end
        end
        pkt_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input int idx, input bit clr);
        @(posedge clk); #1;
        rd_req = 1'b1;
        rd_idx = 4'(idx);
        rd_clr = clr;
        @(posedge clk); #1;
        rd_req = 1'b0;
        rd_clr = 1'b0;
        ov[0] = if0.rd_valid; ob[0] = 64'(if0.rd_byte); op[0] = 64'(if0.rd_pkt);
        ov[1] = if1.rd_valid; ob[1] = 64'(if1.rd_byte); op[1] = 64'(if1.rd_pkt);
        ov[2] = if2.rd_valid; ob[2] = 64'(if2.rd_byte); op[2] = 64'(if2.rd_pkt);
        ov[3] = if3.rd_valid; ob[3] = 64'(if3.rd_byte); op[3] = 64'(if3.rd_pkt);
    endtask

    initial begin
        rst = 1'b1; pkt_data = '0; pkt_wr = 1'b0;
        rd_req = 1'b0; rd_idx = '0; rd_clr = 1'b0; cnt_clr = 1'b0;
        rule_5tuple = '0; rule_mask = '0;
        rule_5tuple[0*104 +: 104] = T_A;  rule_mask[0*104 +: 104] = '1;
        rule_5tuple[1*104 +: 104] = T_B;  rule_mask[1*104 +: 104] = '1;
        rule_5tuple[2*104 +: 104] = {32'h0, 32'h05060708, 40'h0};
        rule_mask[2*104 +: 104]   = {32'h0, 32'hFFFFFFFF, 40'h0};
        rule_5tuple[5*104 +: 104] = {72'h0, 8'h06, 16'h03E8, 16'h0};
        rule_mask[5*104 +: 104]   = {72'h0, 8'hFF, 16'hFFFF, 16'h0};
        rule_en = 8'b0010_0111;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_rd_valid", 64'(if0.rd_valid), 64'd0);
        chk("reset_rd_byte",  64'(if0.rd_byte),  64'd0);
        chk("reset_rd_pkt",   64'(if0.rd_pkt),   64'd0);

        // Untagged UDP, len 96; first read coincides with the update edge
        build_pkt(1'b0, 12'd96, T_A);
        send(0);
        rd(0, 1'b0);
        chk("udp_rd_valid",        64'(ov[0]), 64'd1);
        chk("udp_coincident_pkt",  op[0], 64'd0);
        rd(0, 1'b0);
        chk("udp_rule0_pkt",  op[0], 64'd1);
        chk("udp_rule0_byte", ob[0], 64'd64);
        chk("udp_rule0_byte_bw8", ob[2], 64'd64);
        rd(8, 1'b0);
        chk("udp_miss_pkt",  op[0], 64'd0);
        chk("udp_miss_byte", ob[0], 64'd0);

        // VLAN TCP, len 200, two idle cycles between words
        build_pkt(1'b1, 12'd200, T_B);
        send(2);
        idle(2);
        rd(1, 1'b0);
        chk("vlan_rule1_pkt",  op[0], 64'd1);
        chk("vlan_rule1_byte", ob[0], 64'd168);
        chk("vlan_rule1_pkt_mm1", op[1], 64'd1);
        rd(0, 1'b0);
        chk("vlan_rule0_unchanged", op[0], 64'd1);

        // Overlapping rules 2 and 5
        build_pkt(1'b0, 12'd64, T_C);
        send(0);
        idle(2);
        rd(2, 1'b0);
        chk("mm0_rule2_pkt",  op[0], 64'd1);
        chk("mm0_rule2_byte", ob[0], 64'd32);
        chk("mm1_rule2_pkt",  op[1], 64'd1);
        rd(5, 1'b0);
        chk("mm0_rule5_pkt", op[0], 64'd0);
        chk("mm1_rule5_pkt", op[1], 64'd1);

        // ARP then ICMP: both land on the miss counter
        wq.delete();
        wq.push_back(hdr(12'd60));
        wq.push_back(134'h0);
        wq.push_back({102'h0, 16'h0806, 16'h0});
        wq.push_back(134'h5);
        send(0);
        build_pkt(1'b0, 12'd80, T_ICMP);
        send(0);
        idle(2);
        rd(8, 1'b0);
        chk("abort_miss_pkt", op[0], 64'd2);
        rd(0, 1'b0);
        chk("abort_rule0_pkt", op[0], 64'd1);
        rd(1, 1'b0);
        chk("abort_rule1_pkt", op[0], 64'd1);
        rd(9, 1'b0);
        chk("oob_idx_byte", ob[0], 64'd0);
        chk("oob_idx_pkt",  op[0], 64'd0);

        // Read under cnt_clr returns zero and the counters stay cleared
        cnt_clr = 1'b1;
        rd(1, 1'b0);
        chk("clr_read_pkt",  op[0], 64'd0);
        chk("clr_read_byte", ob[0], 64'd0);
        cnt_clr = 1'b0;
        rd(8, 1'b0);
        chk("clr_miss_pkt", op[0], 64'd0);

        // Five 100-byte payloads: 500 total
        for (int n = 0; n < 5; n++) begin
            build_pkt(1'b0, 12'd132, T_A);
            send(0);
        end
        idle(2);
        rd(0, 1'b0);
        chk("sat_wide_byte", ob[0], 64'd500);
        chk("sat_wide_pkt",  op[0], 64'd5);
        chk("sat_bw8_byte",  ob[2], 64'd255);
        chk("sat_bw8_pkt",   op[2], 64'd5);
        chk("wrap_bw8_byte", ob[3], 64'd244);
        chk("wrap_bw8_pkt",  op[3], 64'd5);

        // Read-clear coinciding with an update of the same counter
        @(posedge clk); #1 cnt_clr = 1'b1;
        @(posedge clk); #1 cnt_clr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            build_pkt(1'b0, 12'd96, T_A);
            send(0);
        end
        idle(2);
        build_pkt(1'b0, 12'd96, T_A);
        send(0);
        rd(0, 1'b1);
        chk("rdclr_coinc_pkt",  op[0], 64'd3);
        chk("rdclr_coinc_byte", ob[0], 64'd192);
        rd(0, 1'b0);
        chk("rdclr_after_pkt",  op[0], 64'd1);
        chk("rdclr_after_byte", ob[0], 64'd64);
        rd(0, 1'b1);
        rd(0, 1'b0);
        chk("rdclr_plain_pkt", op[0], 64'd0);

        // Reset in the middle of a packet; the orphan L4 word must not count
        build_pkt(1'b0, 12'd96, T_A);
        send(0);
        idle(2);
        rd(0, 1'b0);
        chk("prerst_rule0_byte", ob[0], 64'd64);
        build_pkt(1'b0, 12'd96, T_A);
        l4_word = wq.pop_back();
        send(0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_rd_byte",  64'(if0.rd_byte),  64'd0);
        chk("midrst_rd_valid", 64'(if0.rd_valid), 64'd0);
        wq.delete();
        wq.push_back(l4_word);
        send(0);
        idle(2);
        rd(0, 1'b0);
        chk("midrst_rule0_pkt", op[0], 64'd0);
        rd(8, 1'b0);
        chk("midrst_miss_pkt", op[0], 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multi_rule_flow_stat.md
Name: multi_rule_flow_stat

Overview:
Parametrised next-generation 5-tuple flow statistics block for the statistic_and_sample path. It parses the metadata-prefixed 134-bit packet stream, extracts the IPv4 TCP/UDP 5-tuple (untagged or single VLAN tag), and matches it against NUM_RULES masked rules. It keeps per-rule byte/packet counters plus a miss counter, all readable through an indexed read/read-clear port.

Parameters:
NUM_RULES, 8, number of rule slots (1..32)
BYTE_W, 40, byte-counter width
PKT_W, 32, packet-counter width
MATCH_MODE, 0, 0 = first match (lowest index wins), 1 = every matching rule counts
SATURATE, 1, 1 = counters hold at all-ones, 0 = counters wrap modulo 2^W
IDX_W, $clog2(NUM_RULES+1), read-index width (derived)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
pktin_data  in  134  stream word; [133:132]=01 marks the header (first metadata) word
pktin_data_wr  in  1  word valid; the parser advances only on valid cycles
rule_5tuple  in  NUM_RULES*104  rule i at [i*104 +: 104]
rule_mask  in  NUM_RULES*104  1 = bit compared; an all-zero mask matches any parsed packet
rule_en  in  NUM_RULES  per-rule enable
cnt_clr  in  1  level; zeroes every counter while high
rd_req  in  1  read strobe
rd_idx  in  IDX_W  0..NUM_RULES-1 selects a rule; NUM_RULES selects the miss counter
rd_clr  in  1  qualifies rd_req as read-and-clear
rd_valid  out  1  one-cycle pulse, 1 cycle after rd_req
rd_byte  out  BYTE_W  byte count read
rd_pkt  out  PKT_W  packet count read

Behaviour:
- Reset: all counters 0, rd_valid=0, rd_byte=0, rd_pkt=0, parser IDLE, pipeline valids 0. Reset mid-packet discards the packet.
- Tuple layout: [103:72] src IP, [71:40] dst IP, [39:32] protocol, [31:16] src port, [15:0] dst port.
- Parser states (every step advances only on pktin_data_wr=1):
  - IDLE: on a header word, latch len=[107:96]; go to MD1.
  - MD1: second metadata word, no capture; go to ETH.
  - ETH: ethertype at [31:16]. 0x8100 sets vlan=1, 0x0800 sets vlan=0, then go to IP; any other value aborts.
  - IP, vlan=1: requires [127:112]=0x0800 and proto [39:32] in {0x06, 0x11}. Capture proto and src IP [31:16] from [15:0].
  - IP, vlan=0: requires proto [71:64] in {0x06, 0x11}. Capture src IP from [47:16] and dst IP [31:16] from [15:0].
  - L4, vlan=1: src IP lo from [127:112], dst IP from [111:80], sport from [79:64], dport from [63:48].
  - L4, vlan=0: dst IP lo from [127:112], sport from [111:96], dport from [95:80].
  - L4 pulses tuple_vld for one cycle and returns to IDLE.
  - Abort (ETH/IP check fails): pulse nomatch_vld and return to IDLE. The packet counts as a miss.
  - A header word seen in any non-IDLE state restarts the parse at MD1. The interrupted packet is dropped uncounted.
- Byte increment = len-32 when len≥32, else 0.
- Match stage, registered 1 cycle after tuple_vld:
  - hit[i] = rule_en[i] & ~|((tuple^rule_i)&mask_i).
  - MATCH_MODE 0 reduces hit to the lowest set bit.
- Update stage, 1 cycle after match:
  - Each selected rule adds +1 packet and +inc bytes.
  - If no bit is set, or on nomatch_vld, the miss counter updates instead.
  - Total latency, L4 word to counter update: 2 cycles.
- Arithmetic:
  - SATURATE=1: each counter independently clamps at 2^W-1.
  - SATURATE=0: wraps to 0 and continues.
- cnt_clr=1: all counters forced to 0; a coincident update is dropped. The parser keeps running.
- Read:
  - rd_req samples rd_idx; rd_valid, rd_byte and rd_pkt are registered the next cycle.
  - An index greater than NUM_RULES returns 0.
  - With rd_clr=1, the addressed counter is zeroed in the same cycle it is sampled.
  - Read-clear coincident with an update to the same counter: the read returns the pre-update value and the counter becomes exactly the increment. No event is lost or double-counted.
  - A plain read coincident with an update returns the pre-update value.
- rd_req while cnt_clr=1 returns 0.

Decomposition:
- Package flow_stat_pkg holds:
  - TUPLE_W=104 and META_BYTES=32.
  - Ethertype/protocol constants 0x8100, 0x0800, 0x06, 0x11.
  - Tuple field offset localparams.
  - Parser state encoding (IDLE, MD1, ETH, IP, L4).
- Sub-module flow_tuple_parser contains the parser FSM. Outputs: tuple, tuple_vld, nomatch_vld, byte increment.
- The top level holds the match, update, counter array and read port.

Test Plan:
- Untagged UDP, len=96, rule0 = exact tuple with full mask -> after the L4 word + 2 cycles, rule0 reads pkt=1, byte=64; miss reads 0.
- VLAN TCP packet, len=200, gapped by pktin_data_wr=0 cycles between every word -> rule1 (VLAN tuple) reads pkt=1, byte=168. The gaps do not corrupt parsing.
- MATCH_MODE 0 with rule2 and rule5 both matching -> only rule2 increments. MATCH_MODE 1 -> both read pkt=1.
- ARP (ethertype 0x0806) packet, then an IPv4 ICMP packet (proto 0x01) -> miss reads pkt=2; no rule changes.
- BYTE_W=8, SATURATE=1, five packets of len=132 (100 bytes each) -> byte=255, pkt=5. With SATURATE=0, byte=500 mod 256=244.
- rd_req+rd_clr to rule0 in the same cycle as its update (rule0 previously pkt=3) -> rd_pkt=3, then a follow-up read gives pkt=1. Assert rst mid-packet -> no count from that packet.
